// File: rtl/protocol_resp_tx.sv
// Response frame transmitter: header, status, address, command, data (MSB byte first),
// optional XOR checksum (enabled by PROTOCOL_RESP_TX_CHECKSUM_EN), footer; valid/ready byte output.
module protocol_resp_tx #(
  parameter int         DATA_BYTES  = 2,
  parameter logic [7:0] HEADER_BYTE = 8'hFF,
  parameter logic [7:0] FOOTER_BYTE = 8'h7F
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              status,
  input  logic [7:0]              sensor_address,
  input  logic [7:0]              command,
  input  logic [8*DATA_BYTES-1:0] data,
  output logic [7:0]              out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] STATUS = 3'd2;
  localparam logic [2:0] ADDR   = 3'd3;
  localparam logic [2:0] CMD    = 3'd4;
  localparam logic [2:0] DATA   = 3'd5;
`ifdef PROTOCOL_RESP_TX_CHECKSUM_EN
  localparam logic [2:0] CHK    = 3'd6;
`endif
  localparam logic [2:0] FOOTER = 3'd7;

  localparam logic [1:0] LAST_IDX = 2'(DATA_BYTES - 1);

  logic [2:0]              state;
  logic [1:0]              idx;
  logic [7:0]              status_q;
  logic [7:0]              addr_q;
  logic [7:0]              cmd_q;
  logic [8*DATA_BYTES-1:0] data_q;
  logic [7:0]              data_byte;
  logic [2:0]              after_data;
  logic                    transfer;

  // NOTE: every variable written in an always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    data_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (idx == 2'(i)) data_byte = data_q[8*(DATA_BYTES-1-i) +: 8];
    end
  end

`ifdef PROTOCOL_RESP_TX_CHECKSUM_EN
  logic [7:0] chk_byte;

  always_comb begin
    chk_byte = status_q ^ addr_q ^ cmd_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      chk_byte = chk_byte ^ data_q[8*i +: 8];
    end
  end

  assign after_data = CHK;
`else
  assign after_data = FOOTER;
`endif

  // Outputs decode straight from state, so an asynchronous reset clears them at once.
  always_comb begin
    out       = 8'h00;
    out_valid = 1'b1;
    case (state)
      HEADER:  out = HEADER_BYTE;
      STATUS:  out = status_q;
      ADDR:    out = addr_q;
      CMD:     out = cmd_q;
      DATA:    out = data_byte;
`ifdef PROTOCOL_RESP_TX_CHECKSUM_EN
      CHK:     out = chk_byte;
`endif
      FOOTER:  out = FOOTER_BYTE;
      default: out_valid = 1'b0;
    endcase
  end

  assign busy     = (state != IDLE);
  assign transfer = out_valid && out_ready;

  // NOTE: the field registers are few flops, not a memory, so they are reset with the rest
  // of the state and the frame fields read back as zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 2'd0;
      status_q <= 8'h00;
      addr_q   <= 8'h00;
      cmd_q    <= 8'h00;
      data_q   <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            status_q <= status;
            addr_q   <= sensor_address;
            cmd_q    <= command;
            data_q   <= data;
            state    <= HEADER;
          end
        end
        HEADER: if (transfer) state <= STATUS;
        STATUS: if (transfer) state <= ADDR;
        ADDR:   if (transfer) state <= CMD;
        CMD:    if (transfer) state <= DATA;
        DATA: begin
          if (transfer) begin
            if (idx == LAST_IDX) begin
              idx   <= 2'd0;
              state <= after_data;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
`ifdef PROTOCOL_RESP_TX_CHECKSUM_EN
        CHK:    if (transfer) state <= FOOTER;
`endif
        FOOTER: begin
          if (transfer) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
